wb_bram_arbiter: RTL and testbench

//  Two-master Wishbone arbiter sharing one wb_bram slave port (e.g. CPU data bus and DMA engine).

---
 rtl/wb_bram_arbiter.sv | 159 +++++++++++++++
 tb/tb_wb_bram_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bram_arbiter.sv
// Two-master Wishbone arbiter in front of a single wb_bram port: round-robin ownership held for a
// whole bus cycle, burst-limit preemption under contention, and a no-ack watchdog that frees the RAM.
module wb_bram_arbiter #(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);
  localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT - 1);

  state_t     state, state_next;
  logic       last_owner, last_owner_next;
  logic [7:0] burst_cnt, burst_cnt_next;
  logic [7:0] tmo_cnt, tmo_cnt_next;

  logic own0, own1, owning;
  logic owner_cyc, owner_stb, other_cyc;
  logic preempt, timeout, ack_fwd;

  always_comb begin
    own0      = (state == OWN0);
    own1      = (state == OWN1);
    owning    = own0 | own1;
    owner_cyc = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
    owner_stb = (own0 & m0_stb_i) | (own1 & m1_stb_i);
    other_cyc = (own0 & m1_cyc_i) | (own1 & m0_cyc_i);
    // The handover cycle carries no strobe, so a registered slave ack cannot
    // land on the incoming owner for a request issued by the outgoing one.
    preempt   = owning & other_cyc & (burst_cnt == BURST_LIMIT);
    ack_fwd   = s_ack_i & owning & ~preempt;
  end

  always_comb begin
    s_cyc_o = owner_cyc;
    s_stb_o = owner_cyc & owner_stb & ~preempt;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (own0) begin
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
    end else if (own1) begin
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
    end
  end

  // An ack in the last watchdog cycle wins; a dropped cyc removes the strobe and so the error.
  assign timeout  = s_stb_o & ~s_ack_i & (tmo_cnt == TMO_LAST);

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = ack_fwd & own0;
  assign m1_ack_o = ack_fwd & own1;
  assign m0_err_o = timeout & own0;
  assign m1_err_o = timeout & own1;
  assign grant_o  = {own1, own0};

  always_comb begin
    state_next      = state;
    last_owner_next = last_owner;
    burst_cnt_next  = burst_cnt;
    tmo_cnt_next    = tmo_cnt;

    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_next = last_owner ? OWN0 : OWN1;
        end else if (m0_cyc_i) begin
          state_next = OWN0;
        end else if (m1_cyc_i) begin
          state_next = OWN1;
        end
      end
      OWN0: begin
        if (!m0_cyc_i || preempt || timeout) begin
          state_next = m1_cyc_i ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!m1_cyc_i || preempt || timeout) begin
          state_next = m0_cyc_i ? OWN0 : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (state_next != state) begin
      burst_cnt_next = '0;
      tmo_cnt_next   = '0;
      if (state_next == OWN0) begin
        last_owner_next = 1'b0;
      end else if (state_next == OWN1) begin
        last_owner_next = 1'b1;
      end
    end else if (owning) begin
      if (ack_fwd && (burst_cnt != BURST_LIMIT)) begin
        burst_cnt_next = burst_cnt + 8'd1;
      end
      tmo_cnt_next = (s_stb_o && !s_ack_i) ? tmo_cnt + 8'd1 : 8'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      burst_cnt  <= '0;
      tmo_cnt    <= '0;
    end else begin
      state      <= state_next;
      last_owner <= last_owner_next;
      burst_cnt  <= burst_cnt_next;
      tmo_cnt    <= tmo_cnt_next;
    end
  end

endmodule

// File: tb/tb_wb_bram_arbiter.sv
// Directed bench for wb_bram_arbiter with a behavioural wb_bram (registered, toggling ack) as slave.
module tb_wb_bram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [31:0] m0_adr = '0, m0_dat = '0;
  logic [3:0]  m0_sel = '0;
  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [31:0] m1_adr = '0, m1_dat = '0;
  logic [3:0]  m1_sel = '0;
  logic [31:0] m0_rdat, m1_rdat;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_wdat;
  logic [3:0]  s_sel;
  logic [31:0] slave_dat;
  logic        slave_ack;
  logic        s_ack;
  logic [1:0]  grant;

  logic        ack_kill  = 1'b0;
  logic        ack_force = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  wb_bram_arbiter #(.MAX_BURST(8), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_wdat),
    .s_sel_o(s_sel), .s_dat_i(slave_dat), .s_ack_i(s_ack), .grant_o(grant)
  );

  // Behavioural RAM: word k reset to A500_00kk, ack toggles on back-to-back strobes.
  logic [31:0] mem [0:255];

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return 32'hA500_0000 | {24'h0, a[9:2]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slave_ack <= 1'b0;
      slave_dat <= '0;
      for (int k = 0; k < 256; k++) mem[k] <= 32'hA500_0000 | 32'(k);
    end else if (s_cyc && s_stb && !slave_ack && !ack_kill) begin
      slave_ack <= 1'b1;
      if (s_we) mem[s_adr[9:2]] <= merge(mem[s_adr[9:2]], s_wdat, s_sel);
      slave_dat <= mem[s_adr[9:2]];
    end else begin
      slave_ack <= 1'b0;
    end
  end

  assign s_ack = slave_ack | ack_force;

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant); end
    n_cmp++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin n_fail++; $display("FAIL reset_sbus: got cyc/stb/we=%b want 000", {s_cyc, s_stb, s_we}); end
    n_cmp++; if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_ack_err: got %b want 0000", {m0_ack, m1_ack, m0_err, m1_err}); end
    @(posedge clk); #1 rst_n = 1'b1;
    $display("tx reset released");
  endtask

  task automatic test_single_master();
    bit got;
    @(posedge clk); #1;
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h10; m0_dat = 32'hDEADBEEF; m0_sel = 4'hF;
    @(negedge clk);
    n_cmp++; if (grant !== 2'b00) begin n_fail++; $display("FAIL arb_latency: got grant %b want 00", grant); end
    @(negedge clk);
    n_cmp++; if (grant !== 2'b01) begin n_fail++; $display("FAIL m0_grant: got grant %b want 01", grant); end
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (m0_ack) got = 1; else @(negedge clk);
    end
    n_cmp++; if (!got) begin n_fail++; $display("FAIL write_ack: got no ack want ack within 8 cycles"); end
    $display("tx m0 wr adr=%h dat=%h", m0_adr, m0_dat);
    @(posedge clk); #1 m0_we = 0;
    @(negedge clk);
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (m0_ack) got = 1; else @(negedge clk);
    end
    n_cmp++; if (!got) begin n_fail++; $display("FAIL read_ack: got no ack want ack within 8 cycles"); end
    n_cmp++; if (m0_rdat !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data: got %h want deadbeef", m0_rdat); end
    $display("tx m0 rd adr=%h dat=%h", m0_adr, m0_rdat);
    @(posedge clk); #1 m0_cyc = 0; m0_stb = 0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (grant !== 2'b00) begin n_fail++; $display("FAIL release_idle: got grant %b want 00", grant); end
  endtask

  task automatic test_contested_handover();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 m0_cyc = 1; m1_cyc = 1;
    @(negedge clk);
    n_cmp++; if (grant !== 2'b00) begin n_fail++; $display("FAIL contest_latency: got grant %b want 00", grant); end
    @(negedge clk);
    n_cmp++; if (grant !== 2'b01) begin n_fail++; $display("FAIL contest_first: got grant %b want 01", grant); end
    @(posedge clk); #1 m0_cyc = 0;
    @(negedge clk);
    n_cmp++; if (grant !== 2'b01) begin n_fail++; $display("FAIL handover_hold: got grant %b want 01", grant); end
    @(negedge clk);
    n_cmp++; if (grant !== 2'b10) begin n_fail++; $display("FAIL handover_direct: got grant %b want 10", grant); end
    n_cmp++; if (s_cyc !== 1'b1) begin n_fail++; $display("FAIL handover_cyc: got s_cyc %b want 1", s_cyc); end
    $display("tx handover m0->m1 grant=%b", grant);
    @(posedge clk); #1 m1_cyc = 0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (grant !== 2'b00) begin n_fail++; $display("FAIL handover_release: got grant %b want 00", grant); end
  endtask

  task automatic test_burst_preempt();
    int m0_n, m1_n, m0_at_first, m0_at_last, cycles;
    bit m1_started;
    m0_n = 0; m1_n = 0; m0_at_first = -1; m0_at_last = -1; cycles = 0; m1_started = 0;
    @(posedge clk); #1;
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h100; m0_sel = 4'hF;
    while ((m0_n < 20 || m1_n < 4) && cycles < 300) begin
      @(negedge clk);
      cycles++;
      if (m0_ack) begin
        n_cmp++; if (m0_rdat !== exp_word(m0_adr) || grant !== 2'b01) begin n_fail++; $display("FAIL burst_m0_read: got dat %h grant %b want dat %h grant 01", m0_rdat, grant, exp_word(m0_adr)); end
        $display("tx m0 rd adr=%h dat=%h", m0_adr, m0_rdat);
        m0_n++;
      end
      if (m1_ack) begin
        n_cmp++; if (m1_rdat !== exp_word(m1_adr) || grant !== 2'b10) begin n_fail++; $display("FAIL burst_m1_read: got dat %h grant %b want dat %h grant 10", m1_rdat, grant, exp_word(m1_adr)); end
        $display("tx m1 rd adr=%h dat=%h", m1_adr, m1_rdat);
        if (m1_n == 0) m0_at_first = m0_n;
        m1_n++;
        m0_at_last = m0_n;
      end
      @(posedge clk); #1;
      m0_adr = 32'h100 + 32'(4 * m0_n);
      if (m0_n >= 20) begin m0_cyc = 0; m0_stb = 0; end
      if (!m1_started && m0_n >= 3) begin
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_sel = 4'hF; m1_started = 1;
      end
      m1_adr = 32'h200 + 32'(4 * m1_n);
      if (m1_n >= 4) begin m1_cyc = 0; m1_stb = 0; end
    end
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    n_cmp++; if (m0_at_first !== 8) begin n_fail++; $display("FAIL preempt_point: got %0d m0 acks before m1 want 8", m0_at_first); end
    n_cmp++; if (m0_at_last !== 8) begin n_fail++; $display("FAIL preempt_stall: got %0d m0 acks at m1 end want 8", m0_at_last); end
    n_cmp++; if (m0_n !== 20 || m1_n !== 4) begin n_fail++; $display("FAIL burst_totals: got m0=%0d m1=%0d want 20/4", m0_n, m1_n); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (grant !== 2'b00) begin n_fail++; $display("FAIL burst_idle: got grant %b want 00", grant); end
  endtask

  task automatic test_timeout();
    int strobed, err_cycles, err_at, m1_errs;
    logic [1:0] grant_after;
    bit prev_err;
    strobed = 0; err_cycles = 0; err_at = -1; m1_errs = 0; prev_err = 0; grant_after = 2'bxx;
    ack_kill = 1;
    @(posedge clk); #1 m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h300;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (prev_err) grant_after = grant;
      prev_err = m0_err;
      if (grant == 2'b01 && s_stb) strobed++;
      if (m0_err) begin err_cycles++; if (err_at < 0) err_at = strobed; end
      if (m1_err) m1_errs++;
      @(posedge clk); #1;
      if (err_cycles > 0) begin m0_cyc = 0; m0_stb = 0; end
    end
    m0_cyc = 0; m0_stb = 0; ack_kill = 0;
    $display("tx m0 timeout err_at=%0d err_cycles=%0d", err_at, err_cycles);
    n_cmp++; if (err_cycles !== 1) begin n_fail++; $display("FAIL tmo_err_width: got %0d err cycles want 1", err_cycles); end
    n_cmp++; if (err_at !== 16) begin n_fail++; $display("FAIL tmo_err_time: got err at strobed cycle %0d want 16", err_at); end
    n_cmp++; if (m1_errs !== 0) begin n_fail++; $display("FAIL tmo_m1_err: got %0d m1 err cycles want 0", m1_errs); end
    n_cmp++; if (grant_after !== 2'b00) begin n_fail++; $display("FAIL tmo_release: got grant %b want 00", grant_after); end
  endtask

  task automatic test_timeout_races();
    int strobed, errs;
    // run a: owner drops cyc in the watchdog cycle
    strobed = 0; errs = 0;
    ack_kill = 1;
    @(posedge clk); #1 m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h304;
    for (int i = 0; i < 30 && strobed < 15; i++) begin
      @(negedge clk);
      if (grant == 2'b01 && s_stb) strobed++;
      if (m0_err) errs++;
    end
    n_cmp++; if (strobed !== 15) begin n_fail++; $display("FAIL race_drop_setup: got %0d strobed want 15", strobed); end
    @(posedge clk); #1 m0_cyc = 0; m0_stb = 0;
    @(negedge clk);
    if (m0_err) errs++;
    @(negedge clk);
    if (m0_err) errs++;
    n_cmp++; if (errs !== 0) begin n_fail++; $display("FAIL race_drop_err: got %0d err cycles want 0", errs); end
    n_cmp++; if (grant !== 2'b00) begin n_fail++; $display("FAIL race_drop_release: got grant %b want 00", grant); end
    $display("tx m0 drop-in-timeout-cycle errs=%0d", errs);
    // run b: ack arrives in the watchdog cycle
    strobed = 0; errs = 0;
    @(posedge clk); #1 m0_cyc = 1; m0_stb = 1; m0_adr = 32'h308;
    for (int i = 0; i < 30 && strobed < 15; i++) begin
      @(negedge clk);
      if (grant == 2'b01 && s_stb) strobed++;
      if (m0_err) errs++;
    end
    n_cmp++; if (strobed !== 15) begin n_fail++; $display("FAIL race_ack_setup: got %0d strobed want 15", strobed); end
    @(posedge clk); #1 ack_force = 1;
    @(negedge clk);
    n_cmp++; if ({m0_ack, m0_err} !== 2'b10) begin n_fail++; $display("FAIL race_ack_wins: got ack/err %b want 10", {m0_ack, m0_err}); end
    @(posedge clk); #1 ack_force = 0; m0_cyc = 0; m0_stb = 0;
    @(negedge clk);
    if (m0_err) errs++;
    n_cmp++; if (grant !== 2'b01) begin n_fail++; $display("FAIL race_ack_kept: got grant %b want 01", grant); end
    @(negedge clk);
    n_cmp++; if (errs !== 0 || grant !== 2'b00) begin n_fail++; $display("FAIL race_ack_release: got errs %0d grant %b want 0 00", errs, grant); end
    $display("tx m0 ack-in-timeout-cycle errs=%0d", errs);
    ack_kill = 0;
  endtask

  task automatic test_reset_mid_burst();
    int m1_n;
    m1_n = 0;
    @(posedge clk); #1 m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h200; m1_sel = 4'hF;
    for (int i = 0; i < 20 && m1_n < 2; i++) begin
      @(negedge clk);
      if (m1_ack) m1_n++;
    end
    n_cmp++; if (m1_n !== 2) begin n_fail++; $display("FAIL midrst_setup: got %0d m1 acks want 2", m1_n); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({s_cyc, s_stb} !== 2'b00) begin n_fail++; $display("FAIL midrst_async_cyc: got cyc/stb %b want 00", {s_cyc, s_stb}); end
    n_cmp++; if (grant !== 2'b00) begin n_fail++; $display("FAIL midrst_grant: got grant %b want 00", grant); end
    @(posedge clk); #1 m1_cyc = 0; m1_stb = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 m0_cyc = 1; m1_cyc = 1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (grant !== 2'b01) begin n_fail++; $display("FAIL midrst_first_arb: got grant %b want 01", grant); end
    $display("tx reset mid-burst, first arbitration grant=%b", grant);
    @(posedge clk); #1 m0_cyc = 0; m1_cyc = 0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_master();
    test_contested_handover();
    test_burst_preempt();
    test_timeout();
    test_timeout_races();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
